// File: rtl/issue_scoreboard.sv
// Decode-stage hazard/issue controller with a fixed-latency shadow pipeline and halt drain.
// Optional ISSUE_SCOREBOARD_FORWARD_EN: with bypassing, only load-use in ALU stalls.
module issue_scoreboard #(
  parameter int unsigned DEPTH     = 3,
  parameter logic [31:0] HALT_WORD = 32'h8000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             insn_valid,
  input  logic [31:0]      insn,
  input  logic [4:0]       src_rs,
  input  logic [4:0]       src_rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [4:0]       dst_rd,
  input  logic             dst_we,
  input  logic             is_load,
  input  logic             reads_done,
  input  logic             branch_taken,
  output logic             issue,
  output logic             stall,
  output logic             bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e                     state_q, state_d;
  logic [DEPTH-1:0]           valid_q, we_q;
  logic [DEPTH-1:0][4:0]      rd_q;
  logic [CNT_W-1:0]           stall_cnt_q, issue_cnt_q;
  logic                       haz_rs, haz_rt, empty, is_halt;
  logic                       issue_c, stall_c;

`ifdef ISSUE_SCOREBOARD_FORWARD_EN
  logic ld0_q;
  logic unused_tail;
  // Older stages are fully bypassed, so their tracking bits are only shifted.
  assign unused_tail = ^{rd_q[DEPTH-1], we_q[DEPTH-1]};

  always_comb begin
    haz_rs = uses_rs && (src_rs != 5'd0) && valid_q[0] && we_q[0] && ld0_q && (rd_q[0] == src_rs);
    haz_rt = uses_rt && (src_rt != 5'd0) && valid_q[0] && we_q[0] && ld0_q && (rd_q[0] == src_rt);
  end
`else
  logic unused_load;
  assign unused_load = is_load;

  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && we_q[k] && (rd_q[k] == src_rs)) haz_rs = 1'b1;
      if (valid_q[k] && we_q[k] && (rd_q[k] == src_rt)) haz_rt = 1'b1;
    end
    haz_rs = haz_rs && uses_rs && (src_rs != 5'd0);
    haz_rt = haz_rt && uses_rt && (src_rt != 5'd0);
  end
`endif

  assign empty   = (valid_q == '0);
  assign is_halt = (insn == HALT_WORD);

  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    stall_c = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      StRun: begin
        stall_c = insn_valid && (haz_rs || haz_rt) && !branch_taken;
        issue_c = insn_valid && !stall_c && !branch_taken && !is_halt;
        if (insn_valid && is_halt && reads_done && !branch_taken) state_d = StDrain;
      end
      StDrain: begin
        stall_c = 1'b1;
        // A taken branch means the halt word was fetched down a wrong path.
        if (branch_taken)  state_d = StRun;
        else if (empty)    state_d = StHalted;
      end
      StHalted: begin
        stall_c = 1'b1;
        halted  = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  assign issue       = issue_c;
  assign stall       = stall_c;
  assign bubble      = !issue_c;
  assign stall_count = stall_cnt_q;
  assign issue_count = issue_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      valid_q     <= '0;
      we_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
      ld0_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      valid_q[0]  <= issue_c;
      // Writes to $0 are never hazards.
      we_q[0]     <= issue_c && dst_we && (dst_rd != 5'd0);
      rd_q[0]     <= dst_rd;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall_c);
      issue_cnt_q <= issue_cnt_q + CNT_W'(issue_c);
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
      ld0_q       <= issue_c && is_load;
`endif
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: register-busy-window model plus directed literals.
module tb_issue_scoreboard;
  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] HALT  = 32'h8000_0000;
  localparam int unsigned CNT_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic insn_valid = 1'b0, uses_rs = 1'b0, uses_rt = 1'b0, dst_we = 1'b0;
  logic is_load = 1'b0, reads_done = 1'b0, branch_taken = 1'b0;
  logic [31:0] insn = 32'h0;
  logic [4:0] src_rs = 5'd0, src_rt = 5'd0, dst_rd = 5'd0;
  logic issue, stall, bubble, halted;
  logic [CNT_W-1:0] stall_count, issue_count;

  int vectors = 0;
  int miscompares = 0;

  issue_scoreboard #(.DEPTH(DEPTH), .HALT_WORD(HALT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn(insn),
    .src_rs(src_rs), .src_rt(src_rt), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .dst_rd(dst_rd), .dst_we(dst_we), .is_load(is_load), .reads_done(reads_done),
    .branch_taken(branch_taken), .issue(issue), .stall(stall), .bubble(bubble),
    .halted(halted), .stall_count(stall_count), .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register r is busy while its newest producer issued 1..DEPTH cycles ago.
  int cyc, last_issue, mode;  // mode: 0 run, 1 drain, 2 halted
  int last_wr[32];
  int last_ld[32];
  logic [31:0] m_stall, m_issue;
  logic e_issue, e_stall, e_halted;

  task model_init();
    cyc = 0; last_issue = -100; mode = 0; m_stall = 0; m_issue = 0;
    for (int r = 0; r < 32; r++) begin last_wr[r] = -100; last_ld[r] = -100; end
  endtask

  function automatic logic busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
    return last_ld[r] == cyc - 1;
`else
    return (cyc - last_wr[r] >= 1) && (cyc - last_wr[r] <= int'(DEPTH));
`endif
  endfunction

  always @(negedge clock) begin
    logic haz;
    haz = (uses_rs && busy(src_rs)) || (uses_rt && busy(src_rt));
    e_issue = 1'b0; e_stall = 1'b1; e_halted = (mode == 2);
    if (mode == 0) begin
      e_stall = insn_valid && haz && !branch_taken;
      e_issue = insn_valid && !e_stall && !branch_taken && (insn != HALT);
    end
    chk("issue", issue, e_issue);
    chk("stall", stall, e_stall);
    chk("bubble", bubble, !e_issue);
    chk("halted", halted, e_halted);
    chk("stall_count", stall_count, m_stall);
    chk("issue_count", issue_count, m_issue);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) model_init();
    else begin
      if (e_issue) begin
        last_issue = cyc;
        if (dst_we && dst_rd != 5'd0) begin
          last_wr[dst_rd] = cyc;
          last_ld[dst_rd] = is_load ? cyc : -100;
        end
      end
      m_stall = m_stall + 32'(e_stall);
      m_issue = m_issue + 32'(e_issue);
      if (mode == 0) begin
        if (insn_valid && insn == HALT && reads_done && !branch_taken) mode = 1;
      end else if (mode == 1) begin
        if (branch_taken) mode = 0;
        else if (cyc - last_issue > int'(DEPTH)) mode = 2;
      end
      cyc++;
    end
  end

  task automatic set_in(input logic v, input logic [31:0] w, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic rdone, input logic br);
    insn_valid = v; insn = w; src_rs = rs; src_rt = rt; uses_rs = urs; uses_rt = urt;
    dst_rd = rd; dst_we = we; is_load = ld; reads_done = rdone; branch_taken = br;
  endtask

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic idle(); set_in(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_in(1, 32'h0000_0020, rs, rt, 1, 1, rd, 1, 0, 1, 0);
  endtask
  task automatic imm(input logic [4:0] rd, input logic [4:0] rs);
    set_in(1, 32'h2400_0000, rs, 0, 1, 0, rd, 1, 0, 1, 0);
  endtask
  task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
    set_in(1, 32'h8c00_0000, rs, 0, 1, 0, rd, 1, 1, 1, 0);
  endtask
  task automatic halt(input logic rdone);
    set_in(1, HALT, 0, 0, 0, 0, 0, 0, 0, rdone, 0);
  endtask
  task automatic idles(input int n); for (int i = 0; i < n; i++) begin idle(); tick(); end endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_issue", issue, 0);
    chk("rst_bubble", bubble, 1);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", stall_count, 0);
    reset = 1'b0;

    // ADDIU $1 then ADD $2,$1,$1 held in decode
    imm(1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      alu(2, 1, 1); #1;
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
      chk("raw_stall", stall, 0);
`else
      chk("raw_stall", stall, i < 3);
      chk("raw_issue", issue, i == 3);
`endif
      tick();
    end
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
    chk("raw_stall_cnt", stall_count, 0);
    chk("raw_issue_cnt", issue_count, 5);
`else
    chk("raw_stall_cnt", stall_count, 3);
    chk("raw_issue_cnt", issue_count, 2);
`endif

    // $0 producer/consumer never stalls
    idles(4);
    imm(0, 0); #1; chk("r0_issue_a", issue, 1); tick();
    alu(5, 0, 0); #1; chk("r0_issue_b", issue, 1); chk("r0_stall", stall, 0); tick();

    // Stalled consumer killed by a taken branch
    idles(4);
    imm(6, 0); tick();
    alu(7, 6, 6); branch_taken = 1'b1; #1;
    chk("br_issue", issue, 0); chk("br_stall", stall, 0); chk("br_bubble", bubble, 1);
    tick();
    alu(8, 9, 9); #1; chk("br_next_issue", issue, 1); chk("br_next_stall", stall, 0); tick();

    // Halt word before fetch completes is just a bubble
    idles(4);
    halt(0); #1; chk("hw_nd_issue", issue, 0); chk("hw_nd_stall", stall, 0); tick();
    imm(10, 0); #1; chk("hw_nd_run", issue, 1); tick();
    imm(11, 0); tick();
    halt(1); #1; chk("hw_issue", issue, 0); tick();
    for (int i = 0; i < 7; i++) begin
      set_in(1, 32'h0000_0020, 10, 11, 1, 1, 12, 1, 0, 1, i == 5); #1;
      chk("drain_halted", halted, i >= 3);
      chk("drain_stall", stall, 1);
      chk("drain_issue", issue, 0);
      tick();
    end

    // Halt word on a wrong path: branch in DRAIN returns to RUN
    idle(); reset = 1'b1; #2;
    chk("rst2_halted", halted, 0); chk("rst2_stall", stall, 0);
    tick(); reset = 1'b0;
    halt(1); tick();
    imm(13, 0); branch_taken = 1'b1; #1;
    chk("wp_stall", stall, 1); chk("wp_issue", issue, 0); tick();
    imm(13, 0); #1; chk("wp_target", issue, 1); chk("wp_halted", halted, 0); tick();

    // Load-use versus ALU producer
    idles(4);
    lw(3, 0); tick();
    for (int i = 0; i < 4; i++) begin
      alu(4, 3, 3); #1;
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
      chk("lu_stall", stall, i == 0);
`else
      chk("lu_stall", stall, i < 3);
`endif
      tick();
    end
    idles(4);
    imm(3, 0); tick();
    alu(4, 3, 3); #1;
`ifdef ISSUE_SCOREBOARD_FORWARD_EN
    chk("alu_fwd_issue", issue, 1);
`else
    chk("alu_fwd_stall", stall, 1);
`endif
    tick();

    // Reset in the middle of a drain
    idles(4);
    imm(20, 0); tick();
    halt(1); tick();
    idle(); #1; chk("md_stall", stall, 1); tick();
    reset = 1'b1; #1;
    chk("md_halted", halted, 0); chk("md_stall_rst", stall, 0);
    chk("md_bubble", bubble, 1); chk("md_cnt", stall_count, 0);
    tick(); reset = 1'b0;
    idle(); tick();
    #1; chk("md_after_stall", stall, 0); chk("md_after_halted", halted, 0);
    idles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
